// File: rtl/multi_debouncer.sv
// N-channel button debouncer: per-channel synchroniser, symmetric stability filter,
// registered press/release pulses and a long-press / auto-repeat hold pulse.
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] hold
);

    localparam int SW   = $clog2(STABLE_CYCLES);
    localparam int HM0  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HMAX = (HM0 > 2) ? HM0 : 2;
    localparam int HW   = $clog2(HMAX);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_LONG, REPEAT, DONE} hold_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [SW-1:0]          stab_cnt;
        logic [HW-1:0]          hold_cnt;
        hold_state_t            state;
        logic                   level_q, press_q, rel_q, hold_q;
        logic                   s, toggle, level_next;

        assign s          = sync[SYNC_STAGES-1];
        assign toggle     = (s != level_q) && (stab_cnt == STABLE_LAST);
        assign level_next = level_q ^ toggle;

        // The hold FSM follows level_next so a release edge pre-empts a hold in the same cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync     <= '0;
                stab_cnt <= '0;
                hold_cnt <= '0;
                state    <= IDLE;
                level_q  <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                hold_q   <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], raw_in[i]};

                if (s == level_q || stab_cnt == STABLE_LAST)
                    stab_cnt <= '0;
                else
                    stab_cnt <= stab_cnt + 1'b1;

                level_q <= level_next;
                press_q <= toggle & ~level_q;
                rel_q   <= toggle & level_q;
                hold_q  <= 1'b0;

                if (!level_next) begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            state    <= WAIT_LONG;
                            hold_cnt <= '0;
                        end
                        WAIT_LONG: begin
                            if (hold_cnt == LONG_LAST) begin
                                hold_q   <= 1'b1;
                                hold_cnt <= '0;
                                state    <= (REPEAT_CYCLES > 0) ? REPEAT : DONE;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (hold_cnt == REPEAT_LAST) begin
                                hold_q   <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        default: hold_cnt <= '0;
                    endcase
                end
            end
        end

        assign level[i]    = level_q;
        assign press[i]    = press_q;
        assign released[i] = rel_q;
        assign hold[i]     = hold_q;
    end

endmodule
